// File: rtl/wb_arb2_master_if.sv
// Wishbone pipelined bus bundle between the two-port arbiter (master) and a slave.
interface wb_arb2_master_if #(
  parameter int unsigned AW = 8
);

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_stall_i;
  logic [31:0]   wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_stall_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_stall_i, wb_dat_i
  );

endinterface

// File: rtl/wb_arb2_master.sv
// Two-requester round-robin arbiter driving a single Wishbone pipelined master
// port, one transaction at a time, with a per-transaction cycle timeout.
module wb_arb2_master #(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [AW-1:0]         m0_adr_i,
  input  logic [31:0]           m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [31:0]           m0_dat_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [AW-1:0]         m1_adr_i,
  input  logic [31:0]           m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [31:0]           m1_dat_o,
  wb_arb2_master_if.master      wb
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          p0_q, p0_d;
  logic          p1_q, p1_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [DW-1:0] rdat0_q, rdat0_d;
  logic [DW-1:0] rdat1_q, rdat1_d;

  logic          pick;
  logic          tmo;
  logic          done;
  logic          fail;

  // Round-robin pick: on a tie the port not granted last wins, else the lone requester.
  assign pick = (p0_q && p1_q) ? ~last_q : p1_q;

  // Termination conditions; err wins over ack, timeout only counts when the slave is silent.
  assign tmo  = (cnt_q == CW'(TIMEOUT - 1));
  assign done = wb.wb_ack_i | wb.wb_err_i | tmo;
  assign fail = wb.wb_err_i | (tmo & ~wb.wb_ack_i);

  // Next-state and next-output logic for the bus FSM and requester pending bits.
  always_comb begin
    state_d = state_q;
    p0_d    = p0_q | m0_req_i;
    p1_d    = p1_q | m1_req_i;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;

    case (state_q)
      IDLE: begin
        if (p0_q || p1_q) begin
          state_d = ADDR;
          gnt_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = pick ? m1_we_i  : m0_we_i;
          adr_d   = pick ? m1_adr_i : m0_adr_i;
          dat_d   = pick ? m1_dat_i : m0_dat_i;
        end
      end

      ADDR, DATA: begin
        if (done) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          if (gnt_q) begin
            p1_d = 1'b0;
            if (fail) begin
              err1_d = 1'b1;
            end else begin
              ack1_d = 1'b1;
              if (!we_q) rdat1_d = wb.wb_dat_i;
            end
          end else begin
            p0_d = 1'b0;
            if (fail) begin
              err0_d = 1'b1;
            end else begin
              ack0_d = 1'b1;
              if (!we_q) rdat0_d = wb.wb_dat_i;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == ADDR && !wb.wb_stall_i) begin
            state_d = DATA;
            stb_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Arbitration, counter, bus output and requester response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p0_q    <= 1'b0;
      p1_q    <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_sel_o = 4'b1111;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;

  assign m0_ack_o = ack0_q;
  assign m0_err_o = err0_q;
  assign m0_dat_o = rdat0_q;
  assign m1_ack_o = ack1_q;
  assign m1_err_o = err1_q;
  assign m1_dat_o = rdat1_q;

endmodule

// File: tb/tb_wb_arb2_master.sv
// Directed bench for wb_arb2_master: write, round-robin reads, stall, timeout,
// ack+err collision, reset mid-transaction and back-to-back re-request.
module tb_wb_arb2_master;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [31:0]   m0_wdat, m1_wdat;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]   m0_rdat, m1_rdat;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  wb_arb2_master_if #(.AW(AW)) wb ();

  wb_arb2_master #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_req_i (m0_req),
    .m0_we_i  (m0_we),
    .m0_adr_i (m0_adr),
    .m0_dat_i (m0_wdat),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m0_dat_o (m0_rdat),
    .m1_req_i (m1_req),
    .m1_we_i  (m1_we),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_wdat),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .m1_dat_o (m1_rdat),
    .wb       (wb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered in the ADDR cycle of a read by 'port'; slave acks one cycle after stb.
  task automatic read_txn(input bit port, input logic [7:0] adr, input logic [31:0] rd,
                          input bit rereq);
    chk("rd_addr_stb", 32'(wb.wb_stb_o), 32'h1);
    chk("rd_addr_adr", 32'(wb.wb_adr_o), 32'(adr));
    chk("rd_addr_we",  32'(wb.wb_we_o), 32'h0);
    tick();
    chk("rd_data_stb", 32'(wb.wb_stb_o), 32'h0);
    chk("rd_data_cyc", 32'(wb.wb_cyc_o), 32'h1);
    wb.wb_ack_i = 1'b1;
    wb.wb_dat_i = rd;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("rd_ack_own",   32'(port ? m1_ack : m0_ack), 32'h1);
    chk("rd_ack_other", 32'(port ? m0_ack : m1_ack), 32'h0);
    chk("rd_no_err",    32'(m0_err | m1_err), 32'h0);
    chk("rd_data",      port ? m1_rdat : m0_rdat, rd);
    chk("rd_ack_cyc",   32'(wb.wb_cyc_o), 32'h0);
    if (rereq) begin
      if (port) m1_req = 1'b1;
      else      m0_req = 1'b1;
    end
    tick();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdat = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdat = '0;
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_stall_i = 1'b0; wb.wb_dat_i = '0;
    tick();
    tick();

    // Reset values
    chk("rst_cyc", 32'(wb.wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(wb.wb_stb_o), 32'h0);
    chk("rst_we",  32'(wb.wb_we_o), 32'h0);
    chk("rst_adr", 32'(wb.wb_adr_o), 32'h0);
    chk("rst_dat", wb.wb_dat_o, 32'h0);
    chk("rst_sel", 32'(wb.wb_sel_o), 32'hF);
    chk("rst_resp", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
    chk("rst_m0dat", m0_rdat, 32'h0);
    chk("rst_m1dat", m1_rdat, 32'h0);
    rst = 1'b0;

    // Single write from m0: ack pulse lands four cycles after the request
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 8'h00; m0_wdat = 32'h1234_5678;
    tick();
    m0_req = 1'b0;
    chk("wr_c1_cyc", 32'(wb.wb_cyc_o), 32'h0);
    tick();
    chk("wr_c2_cyc", 32'(wb.wb_cyc_o), 32'h1);
    chk("wr_c2_stb", 32'(wb.wb_stb_o), 32'h1);
    chk("wr_c2_we",  32'(wb.wb_we_o), 32'h1);
    chk("wr_c2_adr", 32'(wb.wb_adr_o), 32'h00);
    chk("wr_c2_dat", wb.wb_dat_o, 32'h1234_5678);
    chk("wr_c2_sel", 32'(wb.wb_sel_o), 32'hF);
    tick();
    chk("wr_c3_stb", 32'(wb.wb_stb_o), 32'h0);
    chk("wr_c3_cyc", 32'(wb.wb_cyc_o), 32'h1);
    chk("wr_c3_ack", 32'(m0_ack), 32'h0);
    wb.wb_ack_i = 1'b1;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("wr_c4_ack",  32'(m0_ack), 32'h1);
    chk("wr_c4_err",  32'(m0_err), 32'h0);
    chk("wr_c4_m1",   32'(m1_ack), 32'h0);
    chk("wr_c4_cyc",  32'(wb.wb_cyc_o), 32'h0);
    tick();
    chk("wr_c5_ack", 32'(m0_ack), 32'h0);

    // Tie after m0 was granted last: m1 wins, then m0
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 8'h30;
    m1_req = 1'b1; m1_we = 1'b0; m1_adr = 8'h20;
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    read_txn(1'b1, 8'h20, 32'hAAAA_5555, 1'b0);
    read_txn(1'b0, 8'h30, 32'h0BAD_F00D, 1'b0);
    chk("tie_idle_cyc", 32'(wb.wb_cyc_o), 32'h0);

    // After reset m0 wins the first tie; three alternating rounds
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_adr = 8'h10; m1_adr = 8'h24;
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    read_txn(1'b0, 8'h10, 32'h1111_0000, 1'b1);
    read_txn(1'b1, 8'h24, 32'hAAAA_5555, 1'b1);
    read_txn(1'b0, 8'h10, 32'h2222_0000, 1'b1);
    read_txn(1'b1, 8'h24, 32'h5555_AAAA, 1'b1);
    read_txn(1'b0, 8'h10, 32'h3333_0000, 1'b0);
    read_txn(1'b1, 8'h24, 32'hAAAA_5555, 1'b0);
    chk("rr_idle_cyc", 32'(wb.wb_cyc_o), 32'h0);

    // Stall for three cycles: stb and address held four cycles
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 8'h44; m0_wdat = 32'hDEAD_BEEF;
    tick();
    m0_req = 1'b0;
    tick();
    wb.wb_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("st_stb", 32'(wb.wb_stb_o), 32'h1);
      chk("st_adr", 32'(wb.wb_adr_o), 32'h44);
      chk("st_dat", wb.wb_dat_o, 32'hDEAD_BEEF);
      tick();
    end
    wb.wb_stall_i = 1'b0;
    chk("st_last_stb", 32'(wb.wb_stb_o), 32'h1);
    chk("st_last_adr", 32'(wb.wb_adr_o), 32'h44);
    tick();
    chk("st_d1_stb", 32'(wb.wb_stb_o), 32'h0);
    chk("st_d1_cyc", 32'(wb.wb_cyc_o), 32'h1);
    tick();
    chk("st_d2_stb", 32'(wb.wb_stb_o), 32'h0);
    chk("st_d2_cyc", 32'(wb.wb_cyc_o), 32'h1);
    wb.wb_ack_i = 1'b1;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("st_ack", 32'(m0_ack), 32'h1);
    chk("st_ack_cyc", 32'(wb.wb_cyc_o), 32'h0);
    tick();

    // Timeout with a silent slave: err exactly TMO cycles after ADDR entry
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 8'h08;
    tick();
    m0_req = 1'b0;
    tick();
    chk("to_addr_stb", 32'(wb.wb_stb_o), 32'h1);
    for (int i = 3; i <= 9; i++) begin
      tick();
      chk("to_wait_cyc", 32'(wb.wb_cyc_o), 32'h1);
      chk("to_wait_err", 32'(m0_err), 32'h0);
    end
    tick();
    chk("to_err",   32'(m0_err), 32'h1);
    chk("to_ack",   32'(m0_ack), 32'h0);
    chk("to_cyc",   32'(wb.wb_cyc_o), 32'h0);
    chk("to_m0dat", m0_rdat, 32'h3333_0000);
    tick();
    chk("to_err_once", 32'(m0_err), 32'h0);

    // Simultaneous ack and err is an error; read data untouched
    m1_req = 1'b1; m1_we = 1'b0; m1_adr = 8'h24;
    tick();
    m1_req = 1'b0;
    tick();
    chk("ae_adr", 32'(wb.wb_adr_o), 32'h24);
    tick();
    wb.wb_ack_i = 1'b1; wb.wb_err_i = 1'b1; wb.wb_dat_i = 32'h9999_9999;
    tick();
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0;
    chk("ae_err",    32'(m1_err), 32'h1);
    chk("ae_ack",    32'(m1_ack), 32'h0);
    chk("ae_m0",     32'(m0_ack | m0_err), 32'h0);
    chk("ae_m1dat",  m1_rdat, 32'hAAAA_5555);
    chk("ae_cyc",    32'(wb.wb_cyc_o), 32'h0);
    tick();
    chk("ae_err_once", 32'(m1_err), 32'h0);

    // Reset asserted in DATA aborts silently; late ack ignored in IDLE
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 8'h08;
    tick();
    m0_req = 1'b0;
    tick();
    tick();
    chk("ra_data_cyc", 32'(wb.wb_cyc_o), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_cyc",    32'(wb.wb_cyc_o), 32'h0);
    chk("ra_stb",    32'(wb.wb_stb_o), 32'h0);
    chk("ra_resp",   32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
    chk("ra_m1dat",  m1_rdat, 32'h0);
    wb.wb_ack_i = 1'b1;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("ra_noack",  32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
    chk("ra_cyc2",   32'(wb.wb_cyc_o), 32'h0);
    tick();
    chk("ra_nopend", 32'(wb.wb_cyc_o), 32'h0);

    // Back-to-back: m0 re-requests in its ack cycle and is served after pending m1
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 8'h50; m0_wdat = 32'h0101_0101;
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_adr = 8'h60;
    tick();
    m1_req = 1'b0;
    chk("bb_adr0", 32'(wb.wb_adr_o), 32'h50);
    chk("bb_we0",  32'(wb.wb_we_o), 32'h1);
    tick();
    wb.wb_ack_i = 1'b1;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("bb_ack0", 32'(m0_ack), 32'h1);
    m0_req = 1'b1; m0_adr = 8'h58; m0_wdat = 32'h0202_0202;
    tick();
    m0_req = 1'b0;
    read_txn(1'b1, 8'h60, 32'h0F0F_0F0F, 1'b0);
    chk("bb_stb2", 32'(wb.wb_stb_o), 32'h1);
    chk("bb_adr2", 32'(wb.wb_adr_o), 32'h58);
    chk("bb_we2",  32'(wb.wb_we_o), 32'h1);
    chk("bb_dat2", wb.wb_dat_o, 32'h0202_0202);
    tick();
    wb.wb_ack_i = 1'b1;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("bb_ack2", 32'(m0_ack), 32'h1);
    chk("bb_m1q",  32'(m1_ack), 32'h0);
    tick();
    chk("bb_idle", 32'(wb.wb_cyc_o), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
